// File: rtl/decoder_3to8_hold_if.sv
// decoder_3to8_hold_if: code handshake plus decoded line outputs
interface decoder_3to8_hold_if;
  logic       in_valid;
  logic [0:2] in_code;
  logic       in_ready;
  logic [0:7] out;
  logic       out_valid;
  logic       busy;
  modport master (output in_valid, in_code, input in_ready, out, out_valid, busy);
  modport slave (input in_valid, in_code, output in_ready, out, out_valid, busy);
endinterface

// File: rtl/decoder_3to8_hold.sv
// decoder_3to8_hold: buffered 3-to-8 decoder holding each line HOLD cycles then GAP zeros
module decoder_3to8_hold #(
  parameter int HOLD = 4,
  parameter int GAP = 1
) (
  input logic clk,
  input logic rst_n,
  decoder_3to8_hold_if.slave bus
);
  localparam int MX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] HT = CW'(HOLD - 1);
  localparam logic [CW-1:0] GT = CW'((GAP == 0) ? 0 : GAP - 1);
  typedef enum logic [1:0] {IDLE, DRIVE, GAPW} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [0:7] out_q, out_n, pat;
  logic [0:2] buf_code;
  logic full, pop, push;
  // big-endian one-hot: code 0 lights out[0], the leftmost bit
  assign pat = 8'h80 >> buf_code;
  assign push = bus.in_valid && !full;
  assign bus.in_ready = !full;
  assign bus.out = out_q;
  assign bus.out_valid = state == DRIVE;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    out_n = out_q;
    pop = 1'b0;
    unique case (state)
      IDLE: begin
        out_n = '0;
        cnt_n = '0;
        if (full) begin
          pop = 1'b1;
          out_n = pat;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == HT) begin
          cnt_n = '0;
          if (GAP > 0) begin
            out_n = '0;
            state_n = GAPW;
          end else if (full) begin
            pop = 1'b1;
            out_n = pat;
          end else begin
            out_n = '0;
            state_n = IDLE;
          end
        end
      end
      GAPW: begin
        out_n = '0;
        cnt_n = cnt + 1'b1;
        if (cnt == GT) begin
          cnt_n = '0;
          if (full) begin
            pop = 1'b1;
            out_n = pat;
            state_n = DRIVE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        out_n = '0;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      out_q <= '0;
      full <= 1'b0;
      buf_code <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      out_q <= out_n;
      full <= pop ? 1'b0 : (push ? 1'b1 : full);
      if (push) buf_code <= bus.in_code;
    end
  end
endmodule
